// File: rtl/uart_frame_buffer.sv
// uart_frame_buffer: ping-pong receive frame buffer between a UART receiver
// and a consumer. Two banks of DEPTH words alternate: one fills while the
// oldest completed frame is exposed for random-access reads until acked.
// Optional feature macro: RBUF_TIMEOUT_EN closes a partial frame after
// TIMEOUT_CYCLES idle cycles.
module uart_frame_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 6
`ifdef RBUF_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1000
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         w_data,
    input  logic [$clog2(DEPTH)-1:0] address,
    input  logic                     ack,
    output logic [WIDTH-1:0]         r_data,
    output logic                     frame_ready,
    output logic [$clog2(DEPTH):0]   frame_len,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [AW:0]   FULL_LEN = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [2][DEPTH];
    logic             wbank_r;
    logic             rbank_r;
    logic [AW-1:0]    w_ptr_r;
    logic [1:0]       nfull_r;
    logic [AW:0]      len_r [2];
    logic             overflow_r;

    logic             ack_eff_s;
    logic             accept_s;
    logic             drop_s;
    logic             wr_close_s;
    logic             to_close_s;
    logic             close_s;
    logic [AW:0]      close_len_s;

    // Acceptance: an ack frees its bank first, so a write arriving with it
    // lands in the freed bank instead of being dropped.
    always_comb begin
        ack_eff_s   = ack && (nfull_r != 2'd0);
        accept_s    = wr && ((nfull_r != 2'd2) || ack_eff_s);
        drop_s      = wr && !accept_s;
        wr_close_s  = accept_s && (w_ptr_r == LAST_PTR);
        close_s     = wr_close_s || to_close_s;
        if (wr_close_s) begin
            close_len_s = FULL_LEN;
        end else begin
            close_len_s = {1'b0, w_ptr_r};
        end
    end

`ifdef RBUF_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] IDLE_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] idle_cnt_r;

    // Timeout fires only on a non-empty partial frame while a bank is free.
    always_comb begin
        to_close_s = !wr && (w_ptr_r != {AW{1'b0}}) && (nfull_r != 2'd2)
                     && (idle_cnt_r == IDLE_LAST);
    end

    // Idle counter: cleared by any write or an empty partial frame, held while both banks are full.
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt_r <= {CW{1'b0}};
        end else if (wr || (w_ptr_r == {AW{1'b0}}) || to_close_s) begin
            idle_cnt_r <= {CW{1'b0}};
        end else if (nfull_r == 2'd2) begin
            idle_cnt_r <= idle_cnt_r;
        end else begin
            idle_cnt_r <= idle_cnt_r + CW'(1);
        end
    end
`else
    // Without the timeout feature frames close only when DEPTH words arrive.
    always_comb begin
        to_close_s = 1'b0;
    end
`endif

    // Bank storage; contents survive reset because reads are gated by frame state.
    always_ff @(posedge clk) begin
        if (!reset && accept_s) begin
            mem_r[wbank_r][w_ptr_r] <= w_data;
        end
    end

    // Control state: write pointer, bank selects, full-bank count, lengths, overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wbank_r    <= 1'b0;
            rbank_r    <= 1'b0;
            w_ptr_r    <= {AW{1'b0}};
            nfull_r    <= 2'd0;
            overflow_r <= 1'b0;
            len_r[0]   <= {(AW + 1){1'b0}};
            len_r[1]   <= {(AW + 1){1'b0}};
        end else begin
            if (close_s) begin
                w_ptr_r        <= {AW{1'b0}};
                len_r[wbank_r] <= close_len_s;
                wbank_r        <= ~wbank_r;
            end else if (accept_s) begin
                w_ptr_r <= w_ptr_r + AW'(1);
            end
            if (ack_eff_s) begin
                rbank_r <= ~rbank_r;
            end
            nfull_r <= nfull_r + {1'b0, close_s} - {1'b0, ack_eff_s};
            if (ack_eff_s) begin
                overflow_r <= 1'b0;
            end else if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Read side: expose the oldest completed frame, zero outside its valid words.
    always_comb begin
        frame_ready = (nfull_r != 2'd0);
        fill_level  = {1'b0, w_ptr_r};
        overflow    = overflow_r;
        if (frame_ready) begin
            frame_len = len_r[rbank_r];
        end else begin
            frame_len = {(AW + 1){1'b0}};
        end
        if (frame_ready && ({1'b0, address} < frame_len)) begin
            r_data = mem_r[rbank_r][address];
        end else begin
            r_data = {WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_uart_frame_buffer.sv
// Testbench for uart_frame_buffer: directed scenarios with literal expectations
// followed by randomized traffic checked against a frame-queue reference model.
// Define RBUF_TIMEOUT_EN to build and check the idle-timeout variant.
module tb_uart_frame_buffer;
    localparam int WIDTH = 8;
    localparam int DEPTH = 6;
`ifdef RBUF_TIMEOUT_EN
    localparam int TO = 10;
`endif

    logic       clk;
    logic       reset;
    logic       wr;
    logic [7:0] w_data;
    logic [2:0] address;
    logic       ack;
    logic [7:0] r_data;
    logic       frame_ready;
    logic [3:0] frame_len;
    logic [3:0] fill_level;
    logic       overflow;

    int vectors;
    int errors;
    bit check_en;

    // Reference model: completed frames as a word queue plus a length queue.
    logic [7:0] done_q[$];
    int         lens_q[$];
    logic [7:0] part_q[$];
    bit         m_ovf;
    int         m_idle;

    uart_frame_buffer #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
`ifdef RBUF_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(TO)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .wr(wr),
        .w_data(w_data),
        .address(address),
        .ack(ack),
        .r_data(r_data),
        .frame_ready(frame_ready),
        .frame_len(frame_len),
        .fill_level(fill_level),
        .overflow(overflow)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    task automatic close_frame();
        lens_q.push_back(part_q.size());
        foreach (part_q[i]) done_q.push_back(part_q[i]);
        part_q.delete();
    endtask

    // Model update on each active edge using the inputs the DUT sees.
    always @(posedge clk) begin
        int nf0;
        if (reset) begin
            done_q.delete();
            lens_q.delete();
            part_q.delete();
            m_ovf  = 1'b0;
            m_idle = 0;
        end else begin
            nf0 = lens_q.size();
            if (ack && nf0 > 0) begin
                repeat (lens_q[0]) void'(done_q.pop_front());
                void'(lens_q.pop_front());
                m_ovf = 1'b0;
            end
            if (wr) begin
                m_idle = 0;
                if (lens_q.size() < 2) begin
                    part_q.push_back(w_data);
                    if (part_q.size() == DEPTH) close_frame();
                end else begin
                    m_ovf = 1'b1;
                end
            end
`ifdef RBUF_TIMEOUT_EN
            else if (part_q.size() > 0 && nf0 < 2) begin
                if (m_idle == TO - 1) begin
                    close_frame();
                    m_idle = 0;
                end else begin
                    m_idle++;
                end
            end
`endif
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        int n;
        int el;
        logic [7:0] er;
        if (check_en) begin
            n  = lens_q.size();
            el = (n > 0) ? lens_q[0] : 0;
            er = (n > 0 && int'(address) < el) ? done_q[address] : 8'h00;
            cmp("frame_ready", 32'(frame_ready), 32'(n > 0));
            cmp("frame_len", 32'(frame_len), 32'(el));
            cmp("fill_level", 32'(fill_level), 32'(part_q.size()));
            cmp("overflow", 32'(overflow), 32'(m_ovf));
            cmp("r_data", 32'(r_data), 32'(er));
        end
    end

    task automatic tick(input bit w, input logic [7:0] d, input logic [2:0] a,
                        input bit k, input bit rs);
        wr      = w;
        w_data  = d;
        address = a;
        ack     = k;
        reset   = rs;
        @(posedge clk);
        #1;
        wr    = 1'b0;
        ack   = 1'b0;
        reset = 1'b0;
    endtask

    task automatic read_chk(input string nm, input logic [2:0] a, input logic [7:0] exp);
        address = a;
        #1;
        cmp(nm, 32'(r_data), 32'(exp));
    endtask

    initial begin
        int wp [3];
        int kp [3];
        clk      = 1'b0;
        reset    = 1'b1;
        wr       = 1'b0;
        ack      = 1'b0;
        w_data   = 8'h00;
        address  = 3'd0;
        vectors  = 0;
        errors   = 0;
        check_en = 1'b0;

        // 1: one full frame, reads in and beyond range
        tick(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        check_en = 1'b1;
        cmp("rst_ready", 32'(frame_ready), 32'd0);
        cmp("rst_len", 32'(frame_len), 32'd0);
        cmp("rst_fill", 32'(fill_level), 32'd0);
        cmp("rst_ovf", 32'(overflow), 32'd0);
        cmp("rst_rdata", 32'(r_data), 32'd0);
        for (int i = 0; i < 6; i++) tick(1'b1, 8'(8'h11 + i), 3'd0, 1'b0, 1'b0);
        cmp("t1_ready", 32'(frame_ready), 32'd1);
        cmp("t1_len", 32'(frame_len), 32'd6);
        for (int i = 0; i < 6; i++) read_chk("t1_read", 3'(i), 8'(8'h11 + i));
        read_chk("t1_read7", 3'd7, 8'h00);

        // 2: two frames held, third write dropped, ack releases oldest
        tick(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) tick(1'b1, 8'(8'h20 + i), 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) tick(1'b1, 8'(8'h30 + i), 3'd0, 1'b0, 1'b0);
        tick(1'b1, 8'h40, 3'd0, 1'b0, 1'b0);
        cmp("t2_ovf", 32'(overflow), 32'd1);
        cmp("t2_fill", 32'(fill_level), 32'd0);
        read_chk("t2_read0", 3'd0, 8'h20);
        read_chk("t2_read5", 3'd5, 8'h25);
        tick(1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
        cmp("t2_ovf_clr", 32'(overflow), 32'd0);
        read_chk("t2_ack_read0", 3'd0, 8'h30);

        // 3: ack coincident with the closing write keeps one frame held
        for (int i = 0; i < 5; i++) tick(1'b1, 8'(8'h50 + i), 3'd0, 1'b0, 1'b0);
        tick(1'b1, 8'h55, 3'd0, 1'b1, 1'b0);
        cmp("t3_ready", 32'(frame_ready), 32'd1);
        cmp("t3_fill", 32'(fill_level), 32'd0);
        read_chk("t3_read0", 3'd0, 8'h50);
        read_chk("t3_read5", 3'd5, 8'h55);

        // 4: reset mid-frame discards everything, then a clean frame
        tick(1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 8'(8'h70 + i), 3'd0, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        cmp("t4_ready", 32'(frame_ready), 32'd0);
        cmp("t4_len", 32'(frame_len), 32'd0);
        cmp("t4_fill", 32'(fill_level), 32'd0);
        cmp("t4_rdata", 32'(r_data), 32'd0);
        for (int i = 0; i < 6; i++) tick(1'b1, 8'(8'h60 + i), 3'd0, 1'b0, 1'b0);
        cmp("t4_len6", 32'(frame_len), 32'd6);
        read_chk("t4_read3", 3'd3, 8'h63);

        // 5: ack with nothing ready changes nothing
        tick(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        tick(1'b1, 8'h81, 3'd0, 1'b0, 1'b0);
        tick(1'b1, 8'h82, 3'd0, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
        cmp("t5_ready", 32'(frame_ready), 32'd0);
        cmp("t5_fill", 32'(fill_level), 32'd2);

`ifdef RBUF_TIMEOUT_EN
        // 6: partial frame closed by idle timeout
        tick(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        tick(1'b1, 8'hA1, 3'd0, 1'b0, 1'b0);
        tick(1'b1, 8'hA2, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < TO; i++) tick(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        cmp("t6_ready", 32'(frame_ready), 32'd1);
        cmp("t6_len", 32'(frame_len), 32'd2);
        read_chk("t6_read1", 3'd1, 8'hA2);
        read_chk("t6_read2", 3'd2, 8'h00);
`endif

        // Randomized traffic in phases: overflow-heavy, drain-heavy, sparse
        wp[0] = 80; kp[0] = 5;
        wp[1] = 60; kp[1] = 25;
        wp[2] = 15; kp[2] = 10;
        tick(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 1500; i++) begin
                tick($urandom_range(0, 99) < wp[p], 8'($urandom),
                     3'($urandom_range(0, 7)), $urandom_range(0, 99) < kp[p],
                     $urandom_range(0, 399) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
